reg_file_wb: RTL
================

REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001: clk  input  1  -- single clock; all state updates on the rising edge.
REQ-002: rst_f  input  1  -- reset, synchronous, active-low; sampled on the rising clk edge.
REQ-003: read_rega  input  4  -- read port A register address.
REQ-004: read_regb  input  4  -- read port B register address.
REQ-005: write_reg  input  4  -- writeback destination register address.
REQ-006: write_data  input  32  -- writeback data, driven by the writeback-select mux output.
REQ-007: rf_we  input  1  -- writeback enable; 1 = capture write_data for write_reg.
REQ-008: rsa  output  32  -- read port A data.
REQ-009: rsb  output  32  -- read port B data.
REQ-010: wb_pending  output  1  -- 1 = the writeback stage register holds a write not yet committed.
REQ-011: wr_cnt  output  16  -- count of writes committed to the array since reset.

Function
REQ-012: Storage SHALL be 16 x 32-bit registers R0..R15; R0 always reads 0x00000000.
REQ-013: Writes SHALL pass through a two-stage pipeline: capture stage, then commit stage.
REQ-014: Capture: at a clk edge with rst_f=1, rf_we=1 and write_reg!=0, wb_reg<=write_reg, wb_data<=write_data, wb_pending<=1.
REQ-015: Capture: at a clk edge with rst_f=1 and (rf_we=0 or write_reg=0), wb_pending<=0; wb_reg and wb_data hold.
REQ-016: Writes to R0 SHALL be discarded entirely: no capture, no commit, no wr_cnt change.
REQ-017: Commit: at a clk edge with rst_f=1 and wb_pending=1, R[wb_reg]<=wb_data and wr_cnt<=wr_cnt+1.
REQ-018: Capture and commit on the same edge SHALL both take effect (back-to-back writes sustain one write per cycle).
REQ-019: wr_cnt SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-020: Reads SHALL be combinational: rsa = 0 if read_rega=0; else wb_data if wb_pending=1 and wb_reg=read_rega; else R[read_rega].
REQ-021: rsb SHALL follow REQ-020 using read_regb.
REQ-022: The current-cycle write_data SHALL NOT be bypassed to rsa/rsb; it becomes readable one cycle after capture (via the bypass) and remains readable from the array afterwards.
REQ-023: Both ports reading the same address SHALL return identical data.
REQ-024: Back-to-back writes to the same register: the later write SHALL be the final array value; the bypass SHALL always return the most recently captured value.
REQ-025: Latency: write_data presented at edge N is readable from edge N onward (after N), committed to the array at edge N+1.

Reset
REQ-026: At a clk edge with rst_f=0: all R0..R15<=0, wb_reg<=0, wb_data<=0, wb_pending<=0, wr_cnt<=0.
REQ-027: Reset SHALL take priority over capture and commit; an in-flight write (wb_pending=1) SHALL be dropped, and rf_we SHALL be ignored in that cycle.
REQ-028: Outputs after reset: rsa=rsb=0x00000000 for every address, wb_pending=0, wr_cnt=0x0000.
REQ-029: rst_f deasserted without a clk edge SHALL NOT change state (synchronous only).

Verification
REQ-030: Reset, then write_reg=3, write_data=0xDEADBEEF, rf_we=1 for 1 cycle; read_rega=3 -> rsa=0xDEADBEEF one cycle later via bypass with wb_pending=1; after the next edge rsa=0xDEADBEEF from the array, wb_pending=0, wr_cnt=1.
REQ-031: rf_we=1, write_reg=0, write_data=0x12345678 -> wb_pending stays 0, wr_cnt unchanged, rsa(R0)=0.
REQ-032: Consecutive cycles write R5=0x11111111, then R5=0x22222222 -> rsb(R5)=0x11111111 then 0x22222222; final array R5=0x22222222, wr_cnt+=2.
REQ-033: Capture R7=0xA5A5A5A5, assert rst_f=0 on the next edge -> R7=0, wb_pending=0, wr_cnt=0; rsa(R7)=0.
REQ-034: Preload wr_cnt to 0xFFFF via 65535 writes, perform 1 more write -> wr_cnt=0x0000.
REQ-035: Write R2=0x1 and R9=0x2 on successive cycles, then read_rega=2, read_regb=9 -> rsa=0x00000001, rsb=0x00000002.

Source files
------------

// File: rtl/reg_file_wb.sv
// 16 x 32-bit register file with a two-stage writeback (capture, then commit),
// combinational read ports and a bypass from the pending writeback stage.
module reg_file_wb (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [3:0]  read_rega,
  input  logic [3:0]  read_regb,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        rf_we,
  output logic [31:0] rsa,
  output logic [31:0] rsb,
  output logic        wb_pending,
  output logic [15:0] wr_cnt
);

  logic [3:0]  wb_addr_reg;
  logic [31:0] wb_data_reg;
  logic        wb_pending_reg;
  logic [15:0] wr_cnt_reg;
  logic        capture;
  logic [31:0] rf_q [16];

  // R0 writes never enter the pipeline, so they can never commit or count.
  assign capture = rf_we && (write_reg != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      wb_addr_reg    <= '0;
      wb_data_reg    <= '0;
      wb_pending_reg <= 1'b0;
      wr_cnt_reg     <= '0;
    end else begin
      wb_pending_reg <= capture;
      if (capture) begin
        wb_addr_reg <= write_reg;
        wb_data_reg <= write_data;
      end
      if (wb_pending_reg) begin
        wr_cnt_reg <= wr_cnt_reg + 16'd1;
      end
    end
  end

  assign rf_q[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_reg
      logic [31:0] r_reg;

      always_ff @(posedge clk) begin
        if (!rst_f) begin
          r_reg <= '0;
        end else if (wb_pending_reg && (wb_addr_reg == 4'(gi))) begin
          r_reg <= wb_data_reg;
        end
      end

      assign rf_q[gi] = r_reg;
    end
  endgenerate

  // The pending stage holds the newest value, so it wins over the array.
  function automatic logic [31:0] read_port(input logic [3:0] addr);
    logic [31:0] data;
    data = rf_q[addr];
    if (addr == 4'd0) begin
      data = '0;
    end else if (wb_pending_reg && (wb_addr_reg == addr)) begin
      data = wb_data_reg;
    end
    return data;
  endfunction

  assign rsa        = read_port(read_rega);
  assign rsb        = read_port(read_regb);
  assign wb_pending = wb_pending_reg;
  assign wr_cnt     = wr_cnt_reg;

endmodule
